// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared op encoding and saturation constants for pipe_adder.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest datapath the saturation helpers can describe.
  localparam int SAT_MAX_W = 1024;

  // Largest positive two's-complement value of width w: 0x7F..F.
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < w - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Most negative two's-complement value of width w: 0x80..0.
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
    logic [SAT_MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: CHUNK-bit combinational add with carry in/out. It also
// exposes the carry into its MSB so the top slice can derive signed overflow.
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + (CHUNK+1)'(i_cin);
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_cout = w_full[CHUNK];
  // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it.
  assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit add/sub, one CHUNK slice per stage.
// Stage k adds slice k and registers its carry for stage k+1. The operand
// bits not yet consumed travel down the pipe shifted right, so every stage
// always adds bits [CHUNK-1:0]. Finished low slices ride along in the
// partial-sum registers, which lets all result bits leave together.
// The optional macro PIPE_ADDER_SAT_EN clamps sum on signed overflow.
import pipe_adder_pkg::*;

module pipe_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

`ifdef PIPE_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  logic             w_adv;
  logic [WIDTH-1:0] w_bp;
  logic             w_seed;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1, and a borrow-in removes that +1.
  assign w_bp   = (sub == OP_SUB) ? ~in_2 : in_2;
  assign w_seed = (sub == OP_SUB) ? ~c_in : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] w_a, w_b, w_sp, w_sn, w_sd;
    logic             w_ci, w_vi;
    logic [CHUNK-1:0] w_slice;
    logic             w_co, w_cmsb;
    logic [WIDTH-1:0] r_s;
    logic             r_v;

    if (k == 0) begin : g_in
      assign w_a  = in_1;
      assign w_b  = w_bp;
      assign w_ci = w_seed;
      assign w_sp = '0;
      assign w_vi = in_valid;
    end else begin : g_in
      assign w_a  = g_stg[k-1].g_mid.r_a;
      assign w_b  = g_stg[k-1].g_mid.r_b;
      assign w_ci = g_stg[k-1].g_mid.r_c;
      assign w_sp = g_stg[k-1].r_s;
      assign w_vi = g_stg[k-1].r_v;
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a    (w_a[CHUNK-1:0]),
      .i_b    (w_b[CHUNK-1:0]),
      .i_cin  (w_ci),
      .o_sum  (w_slice),
      .o_cout (w_co),
      .o_cmsb (w_cmsb)
    );

    // Drop this stage's slice into its position in the partial result.
    always_comb begin
      w_sn = w_sp;
      w_sn[k*CHUNK +: CHUNK] = w_slice;
    end

    // Valid bit and partial result advance with the pipe; bubbles carry v=0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vi;
        r_s <= w_sd;
      end
    end

    if (k != STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] r_a, r_b;
      logic             r_c;
      logic             w_unused_cmsb;

      assign w_sd          = w_sn;
      assign w_unused_cmsb = w_cmsb;

      // Forward the unconsumed operand slices and this stage's carry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
          r_c <= 1'b0;
        end else if (w_adv) begin
          r_a <= w_a >> CHUNK;
          r_b <= w_b >> CHUNK;
          r_c <= w_co;
        end
      end
    end else begin : g_last
      logic r_cout, r_ovf;
      logic w_ovf;
      logic w_unused_hi;

      assign w_ovf       = w_cmsb ^ w_co;
      assign w_unused_hi = ^{w_a >> CHUNK, w_b >> CHUNK};

      // Final result, clamped to the signed extreme on overflow when enabled.
      always_comb begin
        w_sd = w_sn;
`ifdef PIPE_ADDER_SAT_EN
        // Overflow needs equal operand signs, so A's sign gives the true sign.
        if (w_ovf) w_sd = w_a[CHUNK-1] ? SAT_MIN : SAT_MAX;
`endif
      end

      // Flags are captured alongside the final slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
        end else if (w_adv) begin
          r_cout <= w_co;
          r_ovf  <= w_ovf;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_v;
  assign sum       = g_stg[STAGES-1].r_s;
  assign c_out     = g_stg[STAGES-1].g_last.r_cout;
  assign ovf       = g_stg[STAGES-1].g_last.r_ovf;

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor, the wide-datapath successor to the team's fixed-width ripple adders. Operands are split into CHUNK-bit slices; each pipeline stage adds one slice and registers its carry for the next, so the critical path is one CHUNK-bit add regardless of WIDTH. It sits between the register-file read ports and the ALU result mux wherever multi-cycle wide arithmetic is acceptable. It provides a valid/ready handshake on both sides, a full-throughput pipeline with stall, and carry-out and signed-overflow flags.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, slice width added per stage; STAGES = WIDTH/CHUNK is a derived localparam.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_1  in  WIDTH  operand A.
- in_2  in  WIDTH  operand B.
- c_in  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = A+B+c_in; 1 = A−B−c_in.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.

## Operation
- Beat accepted when in_valid && in_ready.
- Sub: B' = ~in_2 and carry seed = !c_in. Add: B' = in_2 and seed = c_in.
- Stage k (0..STAGES−1) adds slice k of A and B' plus the registered carry from stage k−1 (the seed for stage 0). Higher slices are skew-delayed. Completed low slices are carried forward in delay registers, so all WIDTH result bits leave together.
- Final stage: c_out = carry out of MSB; ovf = carry into MSB XOR carry out of MSB.
- Each stage holds a valid bit. Global advance = !out_valid || out_ready. On advance, every stage captures its predecessor; stage 0 captures the accepted beat, or a bubble if there is none.
- in_ready = advance (combinational). No beat is dropped or duplicated; results emerge in acceptance order.
- Bubbles propagate with valid = 0; data registers of bubble stages are don't-care.

## Timing
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n+STAGES−1, provided there is no stall. This is STAGES cycles including the accept cycle.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: with out_valid && !out_ready, all stages and outputs hold. in_ready = 0.
- Simultaneous accept and output pop in the same cycle is legal and required at full rate.
- Reset (rst_n low, asynchronous): all valid bits clear; sum = 0, c_out = 0, ovf = 0, out_valid = 0. in_ready = 1 from the first cycle after release.
- Reset mid-operation discards all in-flight beats. No stale result is presented after release.
- out_valid, sum, c_out and ovf are registered outputs. in_ready is combinational from out_valid and out_ready only.

## Configuration
- PIPE_ADDER_SAT_EN defined: when ovf = 1, sum clamps to the signed extreme. It becomes 0x7F..F if the true result is positive overflow, and 0x80..0 if negative. ovf and c_out are still reported unmodified.
- PIPE_ADDER_SAT_EN undefined: sum wraps modulo 2^WIDTH. No clamp logic is generated. Latency is identical in both builds.

## Structure
- Shared package pipe_adder_pkg: op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1, plus the saturation max/min constant functions of WIDTH.
- One sub-module, adder_slice: a CHUNK-bit combinational add with carry in/out and carry-into-MSB output. It is instantiated STAGES times.
- Top level owns all pipeline, skew and valid registers and the handshake.

## Test plan
- WIDTH = 32, CHUNK = 8: add 0xFFFFFFFF + 0x00000001, c_in = 0 -> sum 0x00000000, c_out 1, ovf 0, out_valid 4 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001 -> ovf 1. Sum is 0x80000000 when PIPE_ADDER_SAT_EN is undefined and 0x7FFFFFFF when it is defined.
- sub = 1: 0x00000005 − 0x00000007, c_in = 0 -> sum 0xFFFFFFFE, c_out 0, ovf 0. The same with c_in = 1 -> 0xFFFFFFFD.
- Full carry ripple across slices: 0x00FFFFFF + 0x00000000, c_in = 1 -> 0x01000000 with correct per-slice carry timing.
- 16 back-to-back random beats with out_ready toggled pseudo-randomly -> results match the reference model in order. None are lost or duplicated, and the outputs hold stable while stalled.
- rst_n pulsed low with 3 beats in flight -> out_valid 0 immediately and no result emitted after release. The next accepted beat returns correctly after 4 cycles.
